ddc_out_sel_mc: RTL and testbench

- Multi-channel, mode-switched output selector at the end of the DDC filter chain, after the 4:1 FIR mux.
- Selects the TDM sample stream from one of three sources: FIR output, CIC bypass, or an internal test ramp.
- Reduces the selected stream to the output width with optional round-half-up and saturation.
- Mode changes take effect only at channel-frame boundaries, so a frame never mixes sources.

---
 rtl/ddc_pkg.sv | 16 +
 rtl/ddc_rnd_sat.sv | 83 ++++++++
 rtl/ddc_out_sel_mc.sv | 170 +++++++++++++++++
 tb/tb_ddc_out_sel_mc.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ddc_pkg.sv
// Shared definitions for the DDC output stage: mode codes, switch-FSM encoding.
package ddc_pkg;

  localparam logic [1:0] MODE_FIR = 2'b00;
  localparam logic [1:0] MODE_CIC = 2'b01;
  localparam logic [1:0] MODE_TST = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ddc_rnd_sat.sv
// Two-stage width reducer: round-half-up add (stage 1), slice/saturate (stage 2).
module ddc_rnd_sat #(
  parameter int unsigned INW  = 18,
  parameter int unsigned OUTW = 16,
  parameter int unsigned CHW  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            vld_i,
  input  logic [CHW-1:0]  ch_i,
  input  logic [INW-1:0]  data_i,
  input  logic            rnd_en_i,
  output logic            vld_o,
  output logic [CHW-1:0]  ch_o,
  output logic [OUTW-1:0] data_o,
  output logic            sat_o
);

  localparam int unsigned D = INW - OUTW;

  // Guard bit plus the OUTW MSBs after the optional half-LSB add
  logic [OUTW:0] hi_c;

  generate
    if (D > 0) begin : g_rnd
      logic [INW:0] sum_c;
      logic         unused_lsb_c;
      assign sum_c        = {data_i[INW-1], data_i} + ((INW+1)'(rnd_en_i) << (D - 1));
      assign hi_c         = sum_c[INW:D];
      assign unused_lsb_c = ^sum_c[D-1:0];
    end else begin : g_pass
      logic unused_rnd_c;
      assign hi_c         = {data_i[INW-1], data_i};
      assign unused_rnd_c = rnd_en_i;
    end
  endgenerate

  logic            vld1_q;
  logic [CHW-1:0]  ch1_q;
  logic [OUTW:0]   hi1_q;
  logic            vld2_q;
  logic [CHW-1:0]  ch2_q;
  logic [OUTW-1:0] data2_q;
  logic            sat2_q;
  logic            ovf_c;
  logic [OUTW-1:0] data_c;

  // Only the positive side can overflow when adding a half LSB
  always_comb begin
    ovf_c  = hi1_q[OUTW] ^ hi1_q[OUTW-1];
    data_c = ovf_c ? {1'b0, {(OUTW-1){1'b1}}} : hi1_q[OUTW-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld1_q  <= 1'b0;
      ch1_q   <= '0;
      hi1_q   <= '0;
      vld2_q  <= 1'b0;
      ch2_q   <= '0;
      data2_q <= '0;
      sat2_q  <= 1'b0;
    end else begin
      vld1_q <= vld_i;
      if (vld_i) begin
        ch1_q <= ch_i;
        hi1_q <= hi_c;
      end
      vld2_q <= vld1_q;
      sat2_q <= vld1_q & ovf_c;
      if (vld1_q) begin
        ch2_q   <= ch1_q;
        data2_q <= data_c;
      end
    end
  end

  assign vld_o  = vld2_q;
  assign ch_o   = ch2_q;
  assign data_o = data2_q;
  assign sat_o  = sat2_q;

endmodule

// File: rtl/ddc_out_sel_mc.sv
// DDC output selector: FIR / CIC-bypass / test-ramp source with frame-aligned
// mode switching, followed by the round/saturate width reducer.
module ddc_out_sel_mc
  import ddc_pkg::*;
#(
  parameter int unsigned NCH    = 4,
  parameter int unsigned CICW   = 18,
  parameter int unsigned FIRW   = 16,
  parameter int unsigned OUTW   = 16,
  parameter int unsigned SW_TMO = 255,
  parameter int unsigned CHW    = $clog2(NCH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      mode_req,
  input  logic            rnd_en,
  input  logic            cic_flag,
  input  logic [CHW-1:0]  cic_ch,
  input  logic [CICW-1:0] cic_data,
  input  logic            fir_flag,
  input  logic [CHW-1:0]  fir_ch,
  input  logic [FIRW-1:0] fir_data,
  output logic            out_flag,
  output logic [CHW-1:0]  out_ch,
  output logic [OUTW-1:0] out_data,
  output logic            out_sat,
  output logic [1:0]      mode_act,
  output logic            sw_pend
);

  localparam int unsigned INW = max_u(CICW, FIRW);
  localparam int unsigned TMW = $clog2(SW_TMO + 1);
  localparam logic [CHW-1:0] CH_LAST = CHW'(NCH - 1);

  logic [0:0]      state_q, state_d;
  logic [1:0]      mode_q, mode_d;
  logic [1:0]      tgt_q, tgt_d;
  logic            pend_q, pend_d;
  logic [TMW-1:0]  tmo_q, tmo_d;
  logic [OUTW-1:0] ramp_q, ramp_d;
  logic [CHW-1:0]  tch_q, tch_d;

  logic            acc_c;
  logic [CHW-1:0]  ch_c;
  logic [INW-1:0]  data_c;
  logic            rnd_c;
  logic            last_c;

  // Source select; every source is MSB-aligned to INW so one reducer serves all
  always_comb begin
    acc_c  = 1'b0;
    ch_c   = '0;
    data_c = '0;
    rnd_c  = 1'b0;
    case (mode_q)
      MODE_FIR: begin
        acc_c  = fir_flag;
        ch_c   = fir_ch;
        data_c = INW'(fir_data) << (INW - FIRW);
        rnd_c  = rnd_en;
      end
      MODE_CIC: begin
        acc_c  = cic_flag;
        ch_c   = cic_ch;
        data_c = INW'(cic_data) << (INW - CICW);
        rnd_c  = rnd_en;
      end
      MODE_TST: begin
        acc_c  = 1'b1;
        ch_c   = tch_q;
        data_c = INW'(ramp_q) << (INW - OUTW);
      end
      default: ;
    endcase
    last_c = acc_c && (ch_c == CH_LAST);
  end

  // Mode-switch FSM next state
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    tgt_d   = tgt_q;
    pend_d  = pend_q;
    tmo_d   = tmo_q;
    ramp_d  = ramp_q;
    tch_d   = tch_q;
    if (mode_q == MODE_TST) begin
      ramp_d = ramp_q + OUTW'(1);
      tch_d  = tch_q + CHW'(1);
    end
    case (state_q)
      ST_RUN: begin
        tmo_d = '0;
        if ((mode_req != MODE_RSV) && (mode_req != mode_q)) begin
          tgt_d   = mode_req;
          pend_d  = 1'b1;
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (mode_req == mode_q) begin
          pend_d  = 1'b0;
          tmo_d   = '0;
          state_d = ST_RUN;
        end else begin
          if (mode_req != MODE_RSV) begin
            tgt_d = mode_req;
          end
          // The frame-closing sample still leaves from the old source
          if (last_c || (!acc_c && (tmo_q == TMW'(SW_TMO - 1)))) begin
            mode_d  = tgt_d;
            pend_d  = 1'b0;
            tmo_d   = '0;
            state_d = ST_RUN;
            if (tgt_d == MODE_TST) begin
              ramp_d = '0;
              tch_d  = '0;
            end
          end else if (acc_c) begin
            tmo_d = '0;
          end else begin
            tmo_d = tmo_q + TMW'(1);
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      mode_q  <= MODE_FIR;
      tgt_q   <= MODE_FIR;
      pend_q  <= 1'b0;
      tmo_q   <= '0;
      ramp_q  <= '0;
      tch_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      tgt_q   <= tgt_d;
      pend_q  <= pend_d;
      tmo_q   <= tmo_d;
      ramp_q  <= ramp_d;
      tch_q   <= tch_d;
    end
  end

  ddc_rnd_sat #(
    .INW  (INW),
    .OUTW (OUTW),
    .CHW  (CHW)
  ) u_rnd_sat (
    .clk      (clk),
    .rst      (rst),
    .vld_i    (acc_c),
    .ch_i     (ch_c),
    .data_i   (data_c),
    .rnd_en_i (rnd_c),
    .vld_o    (out_flag),
    .ch_o     (out_ch),
    .data_o   (out_data),
    .sat_o    (out_sat)
  );

  assign mode_act = mode_q;
  assign sw_pend  = pend_q;

endmodule

// File: tb/tb_ddc_out_sel_mc.sv
// Directed bench for ddc_out_sel_mc with an expected-sample scoreboard.
module tb_ddc_out_sel_mc;

  localparam int unsigned NCH = 4, CICW = 18, FIRW = 16, OUTW = 16, SW_TMO = 255, CHW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [1:0]      mode_req = 2'b00;
  logic            rnd_en = 1'b0;
  logic            cic_flag = 1'b0;
  logic [CHW-1:0]  cic_ch = '0;
  logic [CICW-1:0] cic_data = '0;
  logic            fir_flag = 1'b0;
  logic [CHW-1:0]  fir_ch = '0;
  logic [FIRW-1:0] fir_data = '0;
  logic            out_flag;
  logic [CHW-1:0]  out_ch;
  logic [OUTW-1:0] out_data;
  logic            out_sat;
  logic [1:0]      mode_act;
  logic            sw_pend;

  ddc_out_sel_mc #(
    .NCH(NCH), .CICW(CICW), .FIRW(FIRW), .OUTW(OUTW), .SW_TMO(SW_TMO), .CHW(CHW)
  ) dut (
    .clk(clk), .rst(rst), .mode_req(mode_req), .rnd_en(rnd_en),
    .cic_flag(cic_flag), .cic_ch(cic_ch), .cic_data(cic_data),
    .fir_flag(fir_flag), .fir_ch(fir_ch), .fir_data(fir_data),
    .out_flag(out_flag), .out_ch(out_ch), .out_data(out_data), .out_sat(out_sat),
    .mode_act(mode_act), .sw_pend(sw_pend)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CHW-1:0]  ch;
    logic [OUTW-1:0] data;
    logic            sat;
  } smp_t;

  smp_t exp_q[$];
  int   due_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [CHW-1:0] ch, input logic [OUTW-1:0] d, input logic s);
    smp_t e;
    e.ch = ch; e.data = d; e.sat = s;
    exp_q.push_back(e);
    due_q.push_back(cyc + 2);
  endtask

  // Advance one clock, then compare any produced sample with the scoreboard
  task automatic tick();
    smp_t e, o;
    int   due;
    @(posedge clk);
    cyc++;
    #1;
    if (out_flag === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_flag", 32'(out_flag), 32'(0));
      end else begin
        e = exp_q.pop_front();
        due = due_q.pop_front();
        o.ch = out_ch; o.data = out_data; o.sat = out_sat;
        chk("sample", 32'(o), 32'(e));
        chk("latency", 32'(cyc), 32'(due));
      end
    end else if (due_q.size() != 0 && due_q[0] <= cyc) begin
      chk("missing_flag", 32'(out_flag), 32'(1));
      void'(exp_q.pop_front());
      void'(due_q.pop_front());
    end
  endtask

  // Reference CIC reduction: {sat, data}
  function automatic logic [16:0] m_cic(input logic [17:0] d, input logic r);
    int v, q;
    v = int'($signed(d));
    q = r ? ((v + 2) >>> 2) : (v >>> 2);
    if (q > 32767) return {1'b1, 16'h7FFF};
    return {1'b0, 16'(q)};
  endfunction

  task automatic fir_smp(input logic [CHW-1:0] ch, input logic [15:0] d, input logic acc);
    fir_flag = 1'b1; fir_ch = ch; fir_data = d;
    if (acc) push(ch, d, 1'b0);
    tick();
    fir_flag = 1'b0;
  endtask

  task automatic cic_smp(input logic [CHW-1:0] ch, input logic [17:0] d, input logic acc);
    logic [16:0] r;
    cic_flag = 1'b1; cic_ch = ch; cic_data = d;
    r = m_cic(d, rnd_en);
    if (acc) push(ch, r[15:0], r[16]);
    tick();
    cic_flag = 1'b0;
  endtask

  initial begin
    tick(); tick();
    chk("rst_out_flag", 32'(out_flag), 32'(0));
    chk("rst_out_ch", 32'(out_ch), 32'(0));
    chk("rst_out_data", 32'(out_data), 32'(0));
    chk("rst_out_sat", 32'(out_sat), 32'(0));
    chk("rst_mode_act", 32'(mode_act), 32'(0));
    chk("rst_sw_pend", 32'(sw_pend), 32'(0));
    rst = 1'b1;
    tick();

    // FIR pass-through, truncate and round
    fir_smp(2'd2, 16'h8001, 1'b1);
    rnd_en = 1'b1;
    fir_smp(2'd3, 16'h7FFF, 1'b1);
    cic_smp(2'd1, 18'h12345, 1'b0);
    tick(); tick(); tick();

    // FIR -> CIC at frame end, CIC strobes dropped meanwhile
    rnd_en = 1'b0;
    mode_req = 2'b01;
    cic_flag = 1'b1; cic_data = 18'h3FFFF;
    for (int c = 0; c < 4; c++) begin
      cic_ch = 2'(c);
      cic_flag = 1'b1;
      fir_smp(2'(c), 16'(16'h1000 + c), 1'b1);
      chk("sw_pend_frame", 32'(sw_pend), (c < 3) ? 32'(1) : 32'(0));
      chk("mode_act_frame", 32'(mode_act), (c < 3) ? 32'(0) : 32'(1));
    end
    cic_flag = 1'b0;

    // CIC reduction with concurrent FIR strobes ignored
    fir_flag = 1'b1; fir_ch = 2'd0; fir_data = 16'h5555;
    rnd_en = 1'b0; cic_smp(2'd0, 18'h1FFFF, 1'b1);
    rnd_en = 1'b1; cic_smp(2'd1, 18'h1FFFF, 1'b1);
    cic_smp(2'd2, 18'h00006, 1'b1);
    cic_smp(2'd3, 18'h20000, 1'b1);
    fir_flag = 1'b0;
    tick(); tick();
    chk("cic_mode_act", 32'(mode_act), 32'(1));

    // CIC -> test ramp
    rnd_en = 1'b0;
    mode_req = 2'b10;
    for (int c = 0; c < 4; c++) cic_smp(2'(c), 18'(c * 1024), 1'b1);
    chk("tst_mode_act", 32'(mode_act), 32'(2));

    // Full ramp wrap, then leave test mode on the next ch 3
    for (int k = 0; k < 65540; k++) begin
      if (k == 65537) mode_req = 2'b00;
      push(2'(k), 16'(k), 1'b0);
      tick();
      if (k == 65537) chk("tst_leave_pend", 32'(sw_pend), 32'(1));
    end
    chk("tst_leave_mode", 32'(mode_act), 32'(0));
    chk("tst_leave_pend_clr", 32'(sw_pend), 32'(0));
    tick(); tick(); tick();

    // Timeout: FIR stalls mid-frame
    mode_req = 2'b01;
    fir_smp(2'd0, 16'h0100, 1'b1);
    fir_smp(2'd1, 16'h0101, 1'b1);
    for (int i = 0; i < 254; i++) tick();
    chk("tmo_mode_before", 32'(mode_act), 32'(0));
    chk("tmo_pend_before", 32'(sw_pend), 32'(1));
    tick();
    chk("tmo_mode_after", 32'(mode_act), 32'(1));
    chk("tmo_pend_after", 32'(sw_pend), 32'(0));

    // Withdrawn request
    mode_req = 2'b00;
    for (int i = 0; i < 21; i++) tick();
    chk("wd_pend", 32'(sw_pend), 32'(1));
    mode_req = 2'b01;
    tick();
    chk("wd_pend_clr", 32'(sw_pend), 32'(0));
    for (int i = 0; i < 300; i++) tick();
    chk("wd_mode_kept", 32'(mode_act), 32'(1));
    chk("wd_pend_kept", 32'(sw_pend), 32'(0));

    // Reset mid-switch with samples in flight
    mode_req = 2'b00;
    cic_smp(2'd0, 18'h00400, 1'b1);
    cic_smp(2'd1, 18'h00800, 1'b1);
    chk("rst2_pend_before", 32'(sw_pend), 32'(1));
    #2 rst = 1'b0;
    #1;
    chk("rst2_out_flag", 32'(out_flag), 32'(0));
    chk("rst2_out_data", 32'(out_data), 32'(0));
    chk("rst2_sw_pend", 32'(sw_pend), 32'(0));
    chk("rst2_mode_act", 32'(mode_act), 32'(0));
    exp_q.delete();
    due_q.delete();
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst2_no_flag", 32'(out_flag), 32'(0));
    end
    chk("rst2_mode_after", 32'(mode_act), 32'(0));
    chk("sb_empty", 32'(exp_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
